// File: rtl/score_frame_reader.sv
// score_frame_reader
//   Consumer end of the game CPU's score/offset interface. Once per video frame
//   (frame_tick) it latches score and offsets, holds them stable for the
//   renderer, feeds the score back to the CPU, and converts the latched score
//   into four BCD digits with a sequential shift-add-3 engine.
//
// Optional feature: define SCORE_FRAME_READER_HIGH_SCORE_EN to build the
//   best-score register behind high_score. Otherwise high_score is tied to 0.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   frame_tick   one-cycle pulse at start of vertical blank
//   score_in     score from CPU
//   offset_x_in  offsetX from CPU
//   offset_y_in  offsetY from CPU
//   cur_score    latched score, fed back to CPU curScore
//   offset_x     frame-stable X offset, clamped to MAX_X-1
//   offset_y     frame-stable Y offset, clamped to MAX_Y-1
//   bcd          {thousands, hundreds, tens, ones}
//   bcd_valid    one-cycle pulse when bcd updates
//   busy         conversion in progress
//   high_score   best score seen since reset (0 when feature disabled)

module score_frame_reader #(
  parameter int unsigned SCORE_W = 10,
  parameter int unsigned OFS_W   = 11,
  parameter int unsigned MAX_X   = 640,
  parameter int unsigned MAX_Y   = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [OFS_W-1:0]   offset_x_in,
  input  logic [OFS_W-1:0]   offset_y_in,
  output logic [SCORE_W-1:0] cur_score,
  output logic [OFS_W-1:0]   offset_x,
  output logic [OFS_W-1:0]   offset_y,
  output logic [15:0]        bcd,
  output logic               bcd_valid,
  output logic               busy,
  output logic [SCORE_W-1:0] high_score
);

  localparam int unsigned ShW  = 16 + SCORE_W;
  localparam int unsigned CntW = $clog2(SCORE_W + 1);
  localparam logic [OFS_W-1:0] XLim = OFS_W'(MAX_X - 1);
  localparam logic [OFS_W-1:0] YLim = OFS_W'(MAX_Y - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SCORE_W);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [ShW-1:0]    shift_q, shift_adj;
  logic [CntW-1:0]   count_q;
  logic              pending_q;
  logic              start, conv_step, conv_end;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (frame_tick || pending_q) state_d = StConv;
      // count reaches SCORE_W one cycle after the last iteration; that edge
      // publishes the result and enters StDone.
      StConv: if (count_q == LastCnt) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state_q != StIdle);
    bcd_valid = (state_q == StDone);
    start     = (state_q == StIdle) && (frame_tick || pending_q);
    conv_step = (state_q == StConv) && (count_q != LastCnt);
    conv_end  = (state_q == StConv) && (count_q == LastCnt);
  end

  // Add-3 correction on every BCD nibble that would overflow when doubled.
  always_comb begin
    shift_adj = shift_q;
    for (int i = 0; i < 4; i++) begin
      if (shift_q[SCORE_W + 4*i +: 4] >= 4'd5) begin
        shift_adj[SCORE_W + 4*i +: 4] = shift_q[SCORE_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Frame latch and conversion datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_score <= '0;
      offset_x  <= '0;
      offset_y  <= '0;
      bcd       <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        cur_score <= score_in;
        offset_x  <= (offset_x_in > XLim) ? XLim : offset_x_in;
        offset_y  <= (offset_y_in > YLim) ? YLim : offset_y_in;
      end

      // A tick arriving mid-conversion is remembered; several collapse to one.
      if (start)                   pending_q <= 1'b0;
      else if (frame_tick && busy) pending_q <= 1'b1;

      if (start) begin
        shift_q <= {16'b0, (frame_tick ? score_in : cur_score)};
        count_q <= '0;
      end else if (conv_step) begin
        shift_q <= shift_adj << 1;
        count_q <= count_q + CntW'(1);
      end

      if (conv_end) bcd <= shift_q[ShW-1 -: 16];
    end
  end

`ifdef SCORE_FRAME_READER_HIGH_SCORE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      high_score <= '0;
    end else if (frame_tick && (score_in > high_score)) begin
      high_score <= score_in;
    end
  end
`else
  assign high_score = '0;
`endif

endmodule
